inv_sub_bytes_seq: RTL and testbench

INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

---
 rtl/inv_sub_bytes_seq.sv | 161 ++++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes over a 128-bit state, LANES bytes per cycle.
// Optional abort input is enabled by defining INVSUB_ABORT_EN.
module inv_sub_bytes_seq #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
`ifdef INVSUB_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy
);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [3:0] STEP = 4'(LANES % 16);
    localparam logic [3:0] LAST = 4'(16 - LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        case (x)
            8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5; 8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38;
            8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e; 8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
            8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82; 8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87;
            8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44; 8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
            8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32; 8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d;
            8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b; 8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
            8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66; 8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2;
            8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49; 8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
            8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64; 8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16;
            8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc; 8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
            8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50; 8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda;
            8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57; 8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
            8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00; 8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a;
            8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05; 8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
            8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f; 8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02;
            8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03; 8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
            8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41; 8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea;
            8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce; 8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
            8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22; 8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85;
            8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8; 8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
            8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71; 8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89;
            8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e; 8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
            8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b; 8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20;
            8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe; 8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
            8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33; 8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31;
            8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59; 8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
            8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9; 8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d;
            8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f; 8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
            8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d; 8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0;
            8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c; 8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
            8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e; 8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26;
            8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63; 8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
            default: y = 8'h00;
        endcase
        return y;
    endfunction

    state_e        state_q;
    logic [3:0]    idx_q;
    logic [127:0]  buf_q;
    logic [127:0]  buf_d;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;

    logic [3:0]    lane_idx [LANES];
    logic [7:0]    lane_out [LANES];

    // One shared inverse S-box per lane; idx_q stays LANES-aligned so lanes never wrap mid-group.
    genvar gl;
    generate
        for (gl = 0; gl < LANES; gl++) begin : g_lane
            assign lane_idx[gl] = idx_q + 4'(gl);
            assign lane_out[gl] = inv_sbox(buf_q[{lane_idx[gl], 3'b000} +: 8]);
        end
    endgenerate

    always_comb begin
        buf_d = buf_q;
        for (int l = 0; l < LANES; l++) begin
            buf_d[{lane_idx[l], 3'b000} +: 8] = lane_out[l];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            buf_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end
`ifdef INVSUB_ABORT_EN
        else if (abort && state_q != IDLE) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end
`endif
        else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= RUN;
                        buf_q      <= state_in;
                        idx_q      <= 4'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    buf_q <= buf_d;
                    idx_q <= idx_q + STEP;
                    if (idx_q == LAST) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign state_out = buf_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: four instances with LANES = 1, 2, 4, 16.
// Abort sequence is exercised when INVSUB_ABORT_EN is defined.
module tb_inv_sub_bytes_seq;

    localparam int ND = 4;

    logic         clk;
    logic         rst       [ND];
    logic         in_valid  [ND];
    logic         in_ready  [ND];
    logic [127:0] state_in  [ND];
    logic         out_valid [ND];
    logic         out_ready [ND];
    logic [127:0] state_out [ND];
    logic         busy      [ND];
    logic         abort     [ND];

    int checks;
    int failures;
    int lanes_of [ND];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < ND; g++) begin : g_dut
            inv_sub_bytes_seq #(.LANES((g == 3) ? 16 : (1 << g))) u_dut (
                .clk       (clk),
                .rst       (rst[g]),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .state_in  (state_in[g]),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .state_out (state_out[g]),
`ifdef INVSUB_ABORT_EN
                .abort     (abort[g]),
`endif
                .busy      (busy[g])
            );
        end
    endgenerate

    typedef struct {
        int           d;
        logic [127:0] st;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [127:0] rep4(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
        return {4{b3, b2, b1, b0}};
    endfunction

    // Full accept -> RUN -> DONE -> IDLE cycle with out_ready held high.
    task automatic run_op(input int d, input logic [127:0] st, input logic [127:0] req, input string nm);
        int n;
        bit busy_ok;
        chk({nm, "_ready_idle"}, 128'(in_ready[d]), 128'd1);
        state_in[d]  = st;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b1;
        tick();
        in_valid[d] = 1'b0;
        state_in[d] = ~st;
        n = 0;
        busy_ok = 1'b1;
        while (out_valid[d] !== 1'b1 && n < 40) begin
            if (busy[d] !== 1'b1 || in_ready[d] !== 1'b0) busy_ok = 1'b0;
            tick();
            n++;
        end
        chk({nm, "_latency"}, 128'(n), 128'(16 / lanes_of[d]));
        chk({nm, "_busy_in_run"}, 128'(busy_ok), 128'd1);
        chk({nm, "_result"}, state_out[d], req);
        chk({nm, "_ready_done"}, 128'(in_ready[d]), 128'd0);
        chk({nm, "_busy_done"}, 128'(busy[d]), 128'd0);
        tick();
        chk({nm, "_valid_cleared"}, 128'(out_valid[d]), 128'd0);
        chk({nm, "_ready_back"}, 128'(in_ready[d]), 128'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        lanes_of[0] = 1;
        lanes_of[1] = 2;
        lanes_of[2] = 4;
        lanes_of[3] = 16;
        for (int i = 0; i < ND; i++) begin
            rst[i]       = 1'b1;
            in_valid[i]  = 1'b0;
            state_in[i]  = '0;
            out_ready[i] = 1'b0;
            abort[i]     = 1'b0;
        end

        vecs[0] = '{0, {16{8'h00}}, {16{8'h52}}};
        vecs[1] = '{2, {16{8'h63}}, {16{8'h00}}};
        vecs[2] = '{1, {{13{8'h00}}, 8'h16, 8'h7c, 8'h63}, {{13{8'h52}}, 8'hff, 8'h01, 8'h00}};
        vecs[3] = '{0, rep4(8'hed, 8'hca, 8'h63, 8'h7c), rep4(8'h53, 8'h10, 8'h00, 8'h01)};
        vecs[4] = '{2, rep4(8'hed, 8'hca, 8'h63, 8'h7c), rep4(8'h53, 8'h10, 8'h00, 8'h01)};
        vecs[5] = '{1, {8'h63, {15{8'h00}}}, {8'h00, {15{8'h52}}}};
        vecs[6] = '{3, {16{8'h63}}, {16{8'h00}}};
        vecs[7] = '{3, rep4(8'h7c, 8'h16, 8'hed, 8'hca), rep4(8'h01, 8'hff, 8'h53, 8'h10)};

        tick();
        tick();
        for (int i = 0; i < ND; i++) rst[i] = 1'b0;
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("reset_ready_%0d", i), 128'(in_ready[i]), 128'd1);
            chk($sformatf("reset_valid_%0d", i), 128'(out_valid[i]), 128'd0);
            chk($sformatf("reset_busy_%0d", i), 128'(busy[i]), 128'd0);
            chk($sformatf("reset_buf_%0d", i), state_out[i], 128'd0);
        end

        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].d, vecs[v].st, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Consumer stalls for 10 cycles while a new state is being offered.
        begin
            logic [127:0] held;
            int n;
            state_in[0]  = rep4(8'h63, 8'h7c, 8'h16, 8'hed);
            in_valid[0]  = 1'b1;
            out_ready[0] = 1'b0;
            tick();
            n = 0;
            while (out_valid[0] !== 1'b1 && n < 40) begin
                state_in[0] = state_in[0] + 128'h0101;
                tick();
                n++;
            end
            chk("stall_latency", 128'(n), 128'd16);
            held = state_out[0];
            chk("stall_result", held, rep4(8'h00, 8'h01, 8'hff, 8'h53));
            for (int c = 0; c < 10; c++) begin
                state_in[0] = state_in[0] ^ 128'hffff;
                tick();
                chk($sformatf("stall_hold_%0d", c), state_out[0], held);
                chk($sformatf("stall_valid_%0d", c), 128'(out_valid[0]), 128'd1);
                chk($sformatf("stall_ready_%0d", c), 128'(in_ready[0]), 128'd0);
            end
            out_ready[0] = 1'b1;
            in_valid[0]  = 1'b0;
            tick();
            chk("stall_release_valid", 128'(out_valid[0]), 128'd0);
            chk("stall_release_ready", 128'(in_ready[0]), 128'd1);
        end

        // Reset in the fifth RUN cycle discards the partial result.
        begin
            state_in[0]  = {16{8'h63}};
            in_valid[0]  = 1'b1;
            out_ready[0] = 1'b1;
            tick();
            in_valid[0] = 1'b0;
            for (int c = 0; c < 4; c++) tick();
            chk("midrun_busy", 128'(busy[0]), 128'd1);
            rst[0] = 1'b1;
            tick();
            rst[0] = 1'b0;
            chk("midrun_rst_valid", 128'(out_valid[0]), 128'd0);
            chk("midrun_rst_busy", 128'(busy[0]), 128'd0);
            chk("midrun_rst_ready", 128'(in_ready[0]), 128'd1);
            chk("midrun_rst_buf", state_out[0], 128'd0);
            run_op(0, rep4(8'hca, 8'hed, 8'h16, 8'h7c), rep4(8'h10, 8'h53, 8'hff, 8'h01), "after_rst");
        end

`ifdef INVSUB_ABORT_EN
        // Abort in the third RUN cycle; out_valid must never rise afterwards.
        begin
            bit seen;
            state_in[0]  = {16{8'h00}};
            in_valid[0]  = 1'b1;
            out_ready[0] = 1'b1;
            tick();
            in_valid[0] = 1'b0;
            tick();
            tick();
            abort[0] = 1'b1;
            tick();
            abort[0] = 1'b0;
            chk("abort_ready", 128'(in_ready[0]), 128'd1);
            chk("abort_busy", 128'(busy[0]), 128'd0);
            seen = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (out_valid[0] === 1'b1) seen = 1'b1;
                tick();
            end
            chk("abort_no_valid", 128'(seen), 128'd0);
            run_op(0, {16{8'h63}}, {16{8'h00}}, "after_abort");
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
